// File: rtl/jesd204b_tpl_pkg.sv
// ---------------------------------------------------------------------------
// jesd204b_tpl_pkg
// Shared definitions for the JESD204B transport layer (TX and RX sides).
//   - Derived framing constants: padded converter count (MP), lane frame
//     width in bits (FW), octets per lane per frame (F), slots per lane.
//   - Bit offsets of the fields inside one sample word, which is laid out
//     MSB first as {data, control, tail}.
//   - Encoding of the RX frame-alignment states.
// No ports; imported with "import jesd204b_tpl_pkg::*;".
// ---------------------------------------------------------------------------
package jesd204b_tpl_pkg;

  // SEARCH: waiting for a start-of-frame marker; ASSEMBLE: frames aligned.
  typedef enum logic {
    TPL_SEARCH   = 1'b0,
    TPL_ASSEMBLE = 1'b1
  } tpl_state_t;

  // Converter count rounded up to a whole number of converters per lane.
  function automatic int tpl_mp(input int lanes, input int converters);
    return ((converters + lanes - 1) / lanes) * lanes;
  endfunction

  // Width of one lane's share of a frame, in bits.
  function automatic int tpl_fw(input int lanes, input int converters,
                                input int samples, input int sample_size);
    return (samples * sample_size * tpl_mp(lanes, converters)) / lanes;
  endfunction

  // Octets per lane per frame.
  function automatic int tpl_f(input int lanes, input int converters,
                               input int samples, input int sample_size);
    return tpl_fw(lanes, converters, samples, sample_size) / 8;
  endfunction

  // Number of sample slots (including pad slots) carried by each lane.
  function automatic int tpl_slots_per_lane(input int lanes, input int converters,
                                            input int samples);
    return (tpl_mp(lanes, converters) * samples) / lanes;
  endfunction

  // Number of tail bits at the bottom of each sample word.
  function automatic int tpl_tail_width(input int resolution, input int control,
                                        input int sample_size);
    return sample_size - resolution - control;
  endfunction

  // LSB position of the control field inside a sample word.
  function automatic int tpl_ctrl_lsb(input int resolution, input int control,
                                      input int sample_size);
    return tpl_tail_width(resolution, control, sample_size);
  endfunction

  // LSB position of the data field inside a sample word.
  function automatic int tpl_data_lsb(input int resolution, input int sample_size);
    return sample_size - resolution;
  endfunction

endpackage

// File: rtl/jesd204b_tpl_rx_lane_asm.sv
// ---------------------------------------------------------------------------
// jesd204b_tpl_rx_lane_asm
// Per-lane frame assembler. Collects the octets of one lane frame, first
// octet ending up in the most significant position.
// The register keeps octets 0..F-2; the final octet is taken straight from
// the input so that the complete lane frame word is available in the same
// cycle as the last accept, which lets the top register the unpacked
// samples with a single clock of latency.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears the register
//   load   - current octet is octet 0 of a frame (discard older contents)
//   shift  - current octet continues the frame
//   octet  - this lane's incoming octet
//   frame  - lane frame word {stored octets, current octet}, F*8 bits
// ---------------------------------------------------------------------------
module jesd204b_tpl_rx_lane_asm #(
  parameter int F = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [7:0]       octet,
  output logic [8*F-1:0]   frame
);

  if (F == 1) begin : g_direct
    // One octet per frame: nothing to remember between cycles.
    assign frame = octet;
  end else begin : g_shift
    localparam int SW = 8 * (F - 1);

    logic [SW-1:0] sreg;
    logic [SW-1:0] shifted;

    if (F == 2) begin : g_one
      assign shifted = octet;
    end else begin : g_many
      assign shifted = {sreg[SW-9:0], octet};
    end

    // Load starts a fresh frame with zeros above octet 0 so a restarted
    // frame never mixes in octets from a discarded partial frame.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sreg <= '0;
      end else if (load) begin
        sreg <= SW'(octet);
      end else if (shift) begin
        sreg <= shifted;
      end
    end

    assign frame = {sreg, octet};
  end

endmodule

// File: rtl/jesd204b_tpl_rx.sv
// ---------------------------------------------------------------------------
// jesd204b_tpl_rx
// JESD204B receive transport layer. Takes one octet per lane per clock from
// the RX link layer, aligns frames on rx_sof, and unpacks each completed
// frame into per-converter data and control fields with tail bits removed.
// Optional build macro: JESD204B_TPL_RX_TAIL_CHECK_EN adds a tail_err flag
// raised when any tail bit of a real (non-pad) sample is nonzero; without
// it tail_err is tied low.
// Ports:
//   clk              - rising-edge clock
//   reset            - asynchronous active-high reset
//   en               - block enable; low freezes all state
//   rx_valid         - rx_datain carries valid octets this cycle
//   rx_sof           - current octets are octet 0 of a frame on all lanes
//   rx_datain        - lane l octet at [8l+7:8l]
//   rx_dataout       - converter samples, converter 0 in the LSBs
//   rx_ctrlout       - control bits, same ordering as rx_dataout
//   rx_dataout_valid - one-cycle strobe per completed frame
//   frame_err        - one-cycle strobe on a misaligned start-of-frame
//   tail_err         - nonzero tail bits in the last completed frame
// ---------------------------------------------------------------------------
module jesd204b_tpl_rx
  import jesd204b_tpl_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int CONVERTERS  = 8,
  parameter int RESOLUTION  = 11,
  parameter int CONTROL     = 2,
  parameter int SAMPLE_SIZE = 16,
  parameter int SAMPLES     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 rx_valid,
  input  logic                                 rx_sof,
  input  logic [LANES*8-1:0]                   rx_datain,
  output logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] rx_dataout,
  output logic [SAMPLES*CONVERTERS*CONTROL-1:0]    rx_ctrlout,
  output logic                                 rx_dataout_valid,
  output logic                                 frame_err,
  output logic                                 tail_err
);

  localparam int FW       = tpl_fw(LANES, CONVERTERS, SAMPLES, SAMPLE_SIZE);
  localparam int F        = tpl_f(LANES, CONVERTERS, SAMPLES, SAMPLE_SIZE);
  localparam int NS       = CONVERTERS * SAMPLES;
  localparam int DATA_LSB = tpl_data_lsb(RESOLUTION, SAMPLE_SIZE);
  localparam int CTRL_LSB = tpl_ctrl_lsb(RESOLUTION, CONTROL, SAMPLE_SIZE);
  localparam int CW       = (F > 1) ? $clog2(F) : 1;

  tpl_state_t state, state_next;

  logic          accept;
  logic [CW-1:0] cnt, cnt_next, pos;
  logic          load_lane, shift_lane, complete, misalign;

  logic [LANES*FW-1:0]                     all_slots;
  logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] data_next;
  logic [SAMPLES*CONVERTERS*CONTROL-1:0]    ctrl_next;

  assign accept = en & rx_valid;

  // One assembler per lane. Lane words are stacked lane 0 lowest, which
  // makes slot k sit at all_slots[k*SAMPLE_SIZE +: SAMPLE_SIZE] because each
  // lane holds consecutive slots with its lowest slot in the LSBs.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jesd204b_tpl_rx_lane_asm #(
      .F(F)
    ) u_lane_asm (
      .clk   (clk),
      .reset (reset),
      .load  (load_lane),
      .shift (shift_lane),
      .octet (rx_datain[8*l +: 8]),
      .frame (all_slots[FW*l +: FW])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TPL_SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // Alignment is acquired on the first accepted sof and then kept; later
  // misalignment is handled by restarting the frame, not by leaving ASSEMBLE.
  always_comb begin
    state_next = state;
    if (state == TPL_SEARCH && accept && rx_sof) begin
      state_next = TPL_ASSEMBLE;
    end
  end

  // Octet position of the current accept: sof always means octet 0, so a
  // sof arriving mid-frame simply restarts the frame from this octet.
  always_comb begin
    pos        = cnt;
    load_lane  = 1'b0;
    shift_lane = 1'b0;
    complete   = 1'b0;
    misalign   = 1'b0;
    cnt_next   = cnt;
    case (state)
      TPL_SEARCH: begin
        if (accept && rx_sof) begin
          pos       = '0;
          load_lane = 1'b1;
        end
      end
      TPL_ASSEMBLE: begin
        if (accept) begin
          if (rx_sof) begin
            pos       = '0;
            load_lane = 1'b1;
            misalign  = (cnt != '0);
          end else begin
            shift_lane = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (load_lane || shift_lane) begin
      complete = (pos == CW'(F - 1));
      cnt_next = complete ? '0 : pos + 1'b1;
    end
  end

  // Unpack the real slots; pad slots beyond CONVERTERS*SAMPLES are dropped.
  always_comb begin
    data_next = '0;
    ctrl_next = '0;
    for (int k = 0; k < NS; k++) begin
      data_next[k*RESOLUTION +: RESOLUTION] = all_slots[k*SAMPLE_SIZE + DATA_LSB +: RESOLUTION];
      ctrl_next[k*CONTROL +: CONTROL]       = all_slots[k*SAMPLE_SIZE + CTRL_LSB +: CONTROL];
    end
  end

  // Frame counter and output registers; data holds between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt              <= '0;
      rx_dataout       <= '0;
      rx_ctrlout       <= '0;
      rx_dataout_valid <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      cnt              <= cnt_next;
      rx_dataout_valid <= complete;
      frame_err        <= misalign;
      if (complete) begin
        rx_dataout <= data_next;
        rx_ctrlout <= ctrl_next;
      end
    end
  end

`ifdef JESD204B_TPL_RX_TAIL_CHECK_EN
  localparam int TAIL_W = tpl_tail_width(RESOLUTION, CONTROL, SAMPLE_SIZE);
  localparam logic [SAMPLE_SIZE-1:0] TAIL_MASK = SAMPLE_SIZE'((64'd1 << TAIL_W) - 64'd1);

  logic tail_bad;

  // Any set tail bit in a real slot flags the frame.
  always_comb begin
    tail_bad = 1'b0;
    for (int k = 0; k < NS; k++) begin
      tail_bad = tail_bad | (|(all_slots[k*SAMPLE_SIZE +: SAMPLE_SIZE] & TAIL_MASK));
    end
  end

  // Registered alongside the data so it describes the frame on rx_dataout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail_err <= 1'b0;
    end else if (complete) begin
      tail_err <= tail_bad;
    end
  end
`else
  assign tail_err = 1'b0;
`endif

endmodule

// File: tb/tb_jesd204b_tpl_rx.sv
// ---------------------------------------------------------------------------
// tb_jesd204b_tpl_rx
// Directed bench for jesd204b_tpl_rx at default parameters (L=4, M=8,
// N=11, CS=2, N'=16, S=1, so F=4 octets per lane per frame).
// Each table record holds the four rx_datain beats of one frame and the
// hand-computed converter data/control words expected from it.
// ---------------------------------------------------------------------------
module tb_jesd204b_tpl_rx;

`ifdef JESD204B_TPL_RX_TAIL_CHECK_EN
  localparam logic TAIL_ON = 1'b1;
`else
  localparam logic TAIL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [127:0] beats;     // {beat3, beat2, beat1, beat0}
    logic [87:0]  exp_data;
    logic [15:0]  exp_ctrl;
    logic         exp_tail;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        rx_valid;
  logic        rx_sof;
  logic [31:0] rx_datain;
  logic [87:0] rx_dataout;
  logic [15:0] rx_ctrlout;
  logic        rx_dataout_valid;
  logic        frame_err;
  logic        tail_err;

  vec_t vecs [5];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  jesd204b_tpl_rx dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .rx_valid         (rx_valid),
    .rx_sof           (rx_sof),
    .rx_datain        (rx_datain),
    .rx_dataout       (rx_dataout),
    .rx_ctrlout       (rx_ctrlout),
    .rx_dataout_valid (rx_dataout_valid),
    .frame_err        (frame_err),
    .tail_err         (tail_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Inputs change on the falling edge, so outputs read right after this
  // returns reflect every rising edge up to the previous beat.
  task automatic applyStimulus(input logic e, input logic v, input logic s, input logic [31:0] d);
    @(negedge clk);
    en        = e;
    rx_valid  = v;
    rx_sof    = s;
    rx_datain = d;
  endtask

  task automatic sendBeat(input int v, input int b, input logic s);
    applyStimulus(1'b1, 1'b1, s, vecs[v].beats[32*b +: 32]);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic ef,
                             input logic [87:0] ed, input logic [15:0] ec, input logic et);
    compare({name, ".valid"}, 128'(rx_dataout_valid), 128'(ev));
    compare({name, ".frame_err"}, 128'(frame_err), 128'(ef));
    compare({name, ".data"}, 128'(rx_dataout), 128'(ed));
    compare({name, ".ctrl"}, 128'(rx_ctrlout), 128'(ec));
    compare({name, ".tail_err"}, 128'(tail_err), 128'(et));
  endtask

  task automatic checkStrobes(input string name, input logic ev, input logic ef);
    compare({name, ".valid"}, 128'(rx_dataout_valid), 128'(ev));
    compare({name, ".frame_err"}, 128'(frame_err), 128'(ef));
  endtask

  // Main directed sequence.
  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    rx_valid  = 1'b0;
    rx_sof    = 1'b0;
    rx_datain = 32'h0;

    // Converters 0..7 = 67b,6bb,73b,63b,65b,69b,71b,61b, ctrl 0.
    vecs[0] = '{beats: {32'h60606060, 32'he3cbe7cf, 32'h60606060, 32'hc3d3c7d7},
                exp_data: {11'h61b, 11'h71b, 11'h69b, 11'h65b, 11'h63b, 11'h73b, 11'h6bb, 11'h67b},
                exp_ctrl: 16'h0000, exp_tail: 1'b0};
    // All data 7ff, all ctrl 3.
    vecs[1] = '{beats: {32'hf8f8f8f8, 32'hffffffff, 32'hf8f8f8f8, 32'hffffffff},
                exp_data: {8{11'h7ff}}, exp_ctrl: 16'hffff, exp_tail: 1'b0};
    // Converter c: data = c, ctrl = c mod 4.
    vecs[2] = '{beats: {32'hd0805000, 32'h00000000, 32'hf8a87828, 32'h00000000},
                exp_data: {11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0},
                exp_ctrl: 16'he4e4, exp_tail: 1'b0};
    // Converter 7 data MSB only, converter 0 ctrl LSB only.
    vecs[3] = '{beats: {32'h00000008, 32'h00000000, 32'h00000000, 32'h80000000},
                exp_data: {11'h400, 77'd0}, exp_ctrl: 16'h0001, exp_tail: 1'b0};
    // Same as vecs[0] but converter 0 has tail bit 0 set.
    vecs[4] = '{beats: {32'h60606061, 32'he3cbe7cf, 32'h60606060, 32'hc3d3c7d7},
                exp_data: {11'h61b, 11'h71b, 11'h69b, 11'h65b, 11'h63b, 11'h73b, 11'h6bb, 11'h67b},
                exp_ctrl: 16'h0000, exp_tail: TAIL_ON};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    idle();
    checkOutput("post_reset", 1'b0, 1'b0, '0, '0, 1'b0);

    // Single aligned frames from the table.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 4; b++) begin
        sendBeat(i, b, b == 0);
        checkStrobes($sformatf("vec%0d.beat%0d", i, b), 1'b0, 1'b0);
      end
      idle();
      checkOutput($sformatf("vec%0d.done", i), 1'b1, 1'b0,
                  vecs[i].exp_data, vecs[i].exp_ctrl, vecs[i].exp_tail);
      idle();
      checkOutput($sformatf("vec%0d.hold", i), 1'b0, 1'b0,
                  vecs[i].exp_data, vecs[i].exp_ctrl, vecs[i].exp_tail);
    end

    // Back-to-back frames, sof only on the very first octet.
    for (int j = 0; j < 8; j++) begin
      sendBeat((j < 4) ? 0 : 2, j % 4, j == 0);
      if (j == 4) begin
        checkOutput("b2b.first", 1'b1, 1'b0, vecs[0].exp_data, vecs[0].exp_ctrl, 1'b0);
      end else if (j > 4) begin
        checkOutput($sformatf("b2b.gap%0d", j), 1'b0, 1'b0, vecs[0].exp_data, vecs[0].exp_ctrl, 1'b0);
      end else begin
        checkStrobes($sformatf("b2b.beat%0d", j), 1'b0, 1'b0);
      end
    end
    idle();
    checkOutput("b2b.second", 1'b1, 1'b0, vecs[2].exp_data, vecs[2].exp_ctrl, 1'b0);

    // Stalls mid-frame: rx_valid low (with junk and sof), then en low.
    sendBeat(1, 0, 1'b1);
    sendBeat(1, 1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hdeadbeef);
      checkStrobes($sformatf("stall.novalid%0d", s), 1'b0, 1'b0);
    end
    sendBeat(1, 2, 1'b0);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h12345678);
      checkStrobes($sformatf("stall.noen%0d", s), 1'b0, 1'b0);
    end
    sendBeat(1, 3, 1'b0);
    checkStrobes("stall.last", 1'b0, 1'b0);
    idle();
    checkOutput("stall.done", 1'b1, 1'b0, vecs[1].exp_data, vecs[1].exp_ctrl, 1'b0);

    // sof at octet 2: broken frame discarded, new frame starts there.
    sendBeat(0, 0, 1'b1);
    sendBeat(0, 1, 1'b0);
    sendBeat(3, 0, 1'b1);
    checkStrobes("misalign.sof", 1'b0, 1'b0);
    sendBeat(3, 1, 1'b0);
    checkOutput("misalign.err", 1'b0, 1'b1, vecs[1].exp_data, vecs[1].exp_ctrl, 1'b0);
    sendBeat(3, 2, 1'b0);
    checkStrobes("misalign.after", 1'b0, 1'b0);
    sendBeat(3, 3, 1'b0);
    checkStrobes("misalign.last", 1'b0, 1'b0);
    idle();
    checkOutput("misalign.recover", 1'b1, 1'b0, vecs[3].exp_data, vecs[3].exp_ctrl, 1'b0);

    // Reset after octet 2: outputs clear at once, alignment must be regained.
    sendBeat(1, 0, 1'b1);
    sendBeat(1, 1, 1'b0);
    sendBeat(1, 2, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    #1;
    checkOutput("reset.mid", 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sendBeat(2, b, 1'b0);
      checkStrobes($sformatf("reset.nosof%0d", b), 1'b0, 1'b0);
    end
    idle();
    checkOutput("reset.ignored", 1'b0, 1'b0, '0, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      sendBeat(2, b, b == 0);
    end
    idle();
    checkOutput("reset.resync", 1'b1, 1'b0, vecs[2].exp_data, vecs[2].exp_ctrl, 1'b0);
    idle();
    checkStrobes("reset.resync_end", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/jesd204b_tpl_rx.md
Name: jesd204b_tpl_rx

Overview:
JESD204B receive transport layer: the receive-side counterpart of the TX transport layer (jesd204b_tpl_tx).
- Accepts one octet per lane per clock from the RX data link layer.
- Assembles octets into frames, aligned by a start-of-frame marker.
- Unpacks each frame into per-converter samples (data plus control bits), with tail bits stripped.
- Sits between the RX link layer and the converter/application data interface.

Parameters:
- LANES, 4, number of lanes (L).
- CONVERTERS, 8, number of converters (M).
- RESOLUTION, 11, converter resolution (N).
- CONTROL, 2, control bits per sample (CS).
- SAMPLE_SIZE, 16, bits per sample (N'); requires RESOLUTION+CONTROL <= SAMPLE_SIZE.
- SAMPLES, 1, samples per converter per frame (S).
- Derived MP = CONVERTERS padded up to a multiple of LANES.
- Derived FW = SAMPLES*SAMPLE_SIZE*MP/LANES, lane frame width in bits.
- Derived F = FW/8, octets per lane per frame; FW must be a multiple of 8.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- en, input, 1, block enable; when low, inputs are ignored and state holds.
- rx_valid, input, 1, octets on rx_datain are valid this cycle.
- rx_sof, input, 1, current octet is octet 0 of a frame on all lanes; qualified by rx_valid.
- rx_datain, input, LANES*8, lane l octet at bits [8l+7:8l].
- rx_dataout, output, SAMPLES*CONVERTERS*RESOLUTION, converter samples; converter 0 in the LSBs.
- rx_ctrlout, output, SAMPLES*CONVERTERS*CONTROL, control bits, same ordering as rx_dataout.
- rx_dataout_valid, output, 1, one-cycle strobe per completed frame.
- frame_err, output, 1, one-cycle strobe on a misaligned start-of-frame.
- tail_err, output, 1, see Optional Feature.

Behaviour:
- Reset: all outputs 0, octet counter 0, state SEARCH, lane shift registers cleared.
- Accept condition: a cycle is an accept only when en=1 and rx_valid=1. Non-accept cycles freeze the counter and shift registers.
- Frame mapping (inverse of TX):
  - Sample word = {data[N-1:0], ctrl[CS-1:0], tail zeros}, MSB first.
  - Frame slot k (0..MP*S-1) holds converter k/S, sample k%S. Slots >= M*S are pad and are discarded.
  - Lane l carries slots l*MP*S/L up to (l+1)*MP*S/L-1, lowest slot in the LSBs of the lane frame word.
  - The first octet received is the MSB octet of the lane frame word.
- SEARCH state:
  - Drop accepts until one arrives with rx_sof=1.
  - That octet is captured as octet 0, counter := 1, state := ASSEMBLE.
  - If F==1, the frame completes immediately.
- ASSEMBLE state:
  - Each accept shifts the octet into the per-lane shift register and increments the counter.
  - The accept with counter==F-1 completes the frame and sets counter := 0. State stays ASSEMBLE; back-to-back frames need no new rx_sof.
  - rx_sof=1 on an accept when counter != 0: frame_err=1 next cycle, the partial frame is discarded, and the current octet becomes octet 0 (counter := 1).
  - rx_sof=1 when counter==0 is the normal case and raises no error.
  - rx_sof absent at counter==0 is not an error.
- Output timing:
  - On frame completion, rx_dataout, rx_ctrlout and (with the macro) tail_err are registered on the next rising edge, with rx_dataout_valid=1 for that cycle.
  - Latency is one clock from the last-octet accept to valid.
  - Data outputs hold their value until the next completed frame.
  - rx_dataout_valid and frame_err are 0 in every other cycle.
- en low mid-frame: the frame resumes from the held counter when en returns high.
- Reset mid-frame: the partial frame is lost, outputs clear immediately, and the next frame requires rx_sof.

Optional Feature:
- Macro JESD204B_TPL_RX_TAIL_CHECK_EN.
- Defined: on each completed frame, tail_err=1 together with rx_dataout_valid if any tail bit of any non-pad slot is nonzero.
- Not defined: tail_err is tied to 0 and no check logic is built.

Decomposition:
- Package jesd204b_tpl_pkg holds:
  - derived-constant functions (MP, FW, F, slots per lane);
  - the sample field offsets (data, control, tail);
  - the SEARCH/ASSEMBLE state encoding.
- The package is shared with jesd204b_tpl_tx.
- One sub-module, jesd204b_tpl_rx_lane_asm: per-lane F-octet shift register with load-on-sof and shift-on-accept, instantiated LANES times.
- Counter, state machine, unpacking and output registers live in the top level.

Test Plan:
- Single frame, default parameters. Converters 0..7 carry 0x67b, 0x6bb, 0x73b, 0x63b, 0x65b, 0x69b, 0x71b, 0x61b with ctrl=0. Lane 0 octets D7, 60, CF, 60 (sof on the first) -> rx_dataout = {0x61b, 0x71b, ..., 0x67b}, rx_ctrlout=0, rx_dataout_valid=1 exactly one cycle after the 4th octet.
- Back-to-back frames with sof only on the first -> two valid strobes 4 cycles apart, second frame decoded correctly.
- rx_valid low for 3 cycles after octet 1 -> valid is delayed by exactly 3 cycles and the data is unchanged.
- rx_sof asserted at octet 2 -> frame_err pulses once, no valid for the broken frame, and the frame restarting at that octet decodes correctly.
- Reset asserted after octet 2 -> outputs 0 immediately. Post-reset octets without sof are ignored; valid appears only after a sof-aligned frame.
- With the macro, a lane 0 octet of 61 instead of 60 -> tail_err=1 together with valid. Without the macro, tail_err stays 0.
